// File: rtl/bomb_pkg.sv
// bomb_pkg: shared constants and types for the bomb placement path.
package bomb_pkg;
  localparam int GRID_W    = 16;
  localparam int GRID_N    = 256;
  localparam int MAX_BOMBS = 4;
  typedef enum logic {ARB_IDLE, ARB_COOL} arb_state_t;
  typedef enum logic {P1 = 1'b0, P2 = 1'b1} player_t;
  typedef enum logic [1:0] {TILE_EMPTY, TILE_WALL, TILE_BOMB, TILE_FIRE} tile_state_t;
endpackage

// File: rtl/bomb_slot_tracker.sv
// bomb_slot_tracker: per-player fuse slots, lowest-free-slot pick and live count.
module bomb_slot_tracker
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS = 61
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       grant,
  input  logic [2:0] cap,
  output logic [2:0] live,
  output logic       full
);
  logic [6:0] cnt [MAX_BOMBS];
  logic [MAX_BOMBS-1:0] free, pick;
  always_comb begin
    live = '0;
    free = '0;
    for (int i = 0; i < MAX_BOMBS; i++) begin
      free[i] = cnt[i] == 7'd0;
      live = live + 3'(!free[i]);
    end
    pick = free & (~free + 4'd1);
    full = live >= cap;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_BOMBS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < MAX_BOMBS; i++)
        cnt[i] <= (grant && pick[i]) ? 7'(FUSE_TICKS) : cnt[i] - 7'(!free[i]);
    end
  end
endmodule

// File: rtl/bomb_put_arbiter.sv
// bomb_put_arbiter: two-player bomb put arbitration (edge detect, cooldown, capacity, tile shadow, round-robin).
// Define BOMB_ARB_STATS_EN to add saturating grant/conflict counters.
module bomb_put_arbiter
  import bomb_pkg::*;
#(
  parameter int FUSE_TICKS = 61,
  parameter int COOLDOWN   = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              p1_req,
  input  logic              p2_req,
  input  logic [7:0]        p1_cor,
  input  logic [7:0]        p2_cor,
  input  logic [2:0]        p1_cap,
  input  logic [2:0]        p2_cap,
  input  logic [GRID_N-1:0] bomb_un_grid,
  input  logic [GRID_N-1:0] wall_occ,
  output logic              p1_put,
  output logic              p2_put,
  output logic [7:0]        p1_put_cor,
  output logic [7:0]        p2_put_cor,
  output logic              p1_deny,
  output logic              p2_deny,
`ifdef BOMB_ARB_STATS_EN
  output logic [7:0]        p1_grant_cnt,
  output logic [7:0]        p2_grant_cnt,
  output logic [7:0]        conflict_cnt,
`endif
  output logic [2:0]        p1_live,
  output logic [2:0]        p2_live
);
  localparam int CW = $clog2(COOLDOWN + 1);
  logic [1:0] req, req_q, rise, elig, grant, full, put, deny;
  logic [7:0] cor [2];
  logic [7:0] put_cor [2];
  logic [7:0] sh_cor [2];
  logic [1:0] sh_cnt [2];
  logic [2:0] cap [2];
  logic [2:0] live [2];
  logic [CW-1:0] cd [2];
  logic [CW-1:0] cd_n [2];
  arb_state_t st [2];
  arb_state_t st_n [2];
  player_t prio;
  logic started, conflict;
  assign req = {p2_req, p1_req};
  // started masks the first edge after reset so a held request is not seen as a rise
  assign rise = req & ~req_q & {2{started}};
  always_comb begin
    cor[0] = p1_cor;
    cor[1] = p2_cor;
    cap[0] = p1_cap == 3'd0 ? 3'd1 : p1_cap > 3'd4 ? 3'd4 : p1_cap;
    cap[1] = p2_cap == 3'd0 ? 3'd1 : p2_cap > 3'd4 ? 3'd4 : p2_cap;
    for (int i = 0; i < 2; i++)
      elig[i] = st[i] == ARB_IDLE && !wall_occ[cor[i]] && !bomb_un_grid[cor[i]] && !full[i]
             && !(sh_cnt[0] != 2'd0 && sh_cor[0] == cor[i])
             && !(sh_cnt[1] != 2'd0 && sh_cor[1] == cor[i]);
    conflict = &rise && &elig && cor[0] == cor[1];
    grant[0] = rise[0] && elig[0] && !(conflict && prio == P2);
    grant[1] = rise[1] && elig[1] && !(conflict && prio == P1);
    for (int i = 0; i < 2; i++) begin
      st_n[i] = st[i] == ARB_IDLE ? (grant[i] ? ARB_COOL : ARB_IDLE)
                                  : (cd[i] == CW'(1) ? ARB_IDLE : ARB_COOL);
      cd_n[i] = grant[i] ? CW'(COOLDOWN) : cd[i] - CW'(cd[i] != '0);
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_slot
    bomb_slot_tracker #(.FUSE_TICKS(FUSE_TICKS)) u_slot (
      .clk    (clk),
      .reset_n(reset_n),
      .grant  (grant[g]),
      .cap    (cap[g]),
      .live   (live[g]),
      .full   (full[g])
    );
  end
  // shadow covers the put cycle plus the two cycles after it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      started <= 1'b0;
      req_q   <= '0;
      put     <= '0;
      deny    <= '0;
      prio    <= P1;
      for (int i = 0; i < 2; i++) begin
        st[i]      <= ARB_IDLE;
        cd[i]      <= '0;
        put_cor[i] <= '0;
        sh_cor[i]  <= '0;
        sh_cnt[i]  <= '0;
      end
    end else begin
      started <= 1'b1;
      req_q   <= req;
      put     <= grant;
      deny    <= rise & ~grant;
      prio    <= conflict ? player_t'(~prio) : prio;
      for (int i = 0; i < 2; i++) begin
        st[i]      <= st_n[i];
        cd[i]      <= cd_n[i];
        put_cor[i] <= grant[i] ? cor[i] : put_cor[i];
        sh_cor[i]  <= grant[i] ? cor[i] : sh_cor[i];
        sh_cnt[i]  <= grant[i] ? 2'd3 : sh_cnt[i] - 2'(sh_cnt[i] != 2'd0);
      end
    end
  end
`ifdef BOMB_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_grant_cnt <= '0;
      p2_grant_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      p1_grant_cnt <= p1_grant_cnt + 8'(grant[0] && p1_grant_cnt != 8'hff);
      p2_grant_cnt <= p2_grant_cnt + 8'(grant[1] && p2_grant_cnt != 8'hff);
      conflict_cnt <= conflict_cnt + 8'(conflict && conflict_cnt != 8'hff);
    end
  end
`endif
  assign p1_put     = put[0];
  assign p2_put     = put[1];
  assign p1_deny    = deny[0];
  assign p2_deny    = deny[1];
  assign p1_put_cor = put_cor[0];
  assign p2_put_cor = put_cor[1];
  assign p1_live    = live[0];
  assign p2_live    = live[1];
endmodule

// File: tb/tb_bomb_put_arbiter.sv
// tb_bomb_put_arbiter: directed table-driven bench for bomb_put_arbiter.
module tb_bomb_put_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  logic p1_req, p2_req;
  logic [7:0] p1_cor, p2_cor;
  logic [2:0] p1_cap, p2_cap;
  logic [255:0] bomb_un_grid, wall_occ;
  logic p1_put, p2_put, p1_deny, p2_deny;
  logic [7:0] p1_put_cor, p2_put_cor;
  logic [2:0] p1_live, p2_live;
`ifdef BOMB_ARB_STATS_EN
  logic [7:0] p1_grant_cnt, p2_grant_cnt, conflict_cnt;
`endif
  int n_vec = 0;
  int n_err = 0;

  bomb_put_arbiter dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .p1_req      (p1_req),
    .p2_req      (p2_req),
    .p1_cor      (p1_cor),
    .p2_cor      (p2_cor),
    .p1_cap      (p1_cap),
    .p2_cap      (p2_cap),
    .bomb_un_grid(bomb_un_grid),
    .wall_occ    (wall_occ),
    .p1_put      (p1_put),
    .p2_put      (p2_put),
    .p1_put_cor  (p1_put_cor),
    .p2_put_cor  (p2_put_cor),
    .p1_deny     (p1_deny),
    .p2_deny     (p2_deny),
`ifdef BOMB_ARB_STATS_EN
    .p1_grant_cnt(p1_grant_cnt),
    .p2_grant_cnt(p2_grant_cnt),
    .conflict_cnt(conflict_cnt),
`endif
    .p1_live     (p1_live),
    .p2_live     (p2_live)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r1, r2;
    logic [7:0] c1, c2;
    logic [2:0] k1, k2;
    logic [8:0] wall, bomb;
    logic p1, p2, d1, d2;
    logic [2:0] l1, l2;
    logic [7:0] pc1, pc2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r1, input logic r2, input logic [7:0] c1, input logic [7:0] c2,
                              input logic [2:0] k1, input logic [2:0] k2, input logic [8:0] wall,
                              input logic [8:0] bomb, input logic p1, input logic p2, input logic d1,
                              input logic d2, input logic [2:0] l1, input logic [2:0] l2,
                              input logic [7:0] pc1, input logic [7:0] pc2);
    vec_t t;
    t.r1 = r1; t.r2 = r2; t.c1 = c1; t.c2 = c2; t.k1 = k1; t.k2 = k2;
    t.wall = wall; t.bomb = bomb; t.p1 = p1; t.p2 = p2; t.d1 = d1; t.d2 = d2;
    t.l1 = l1; t.l2 = l2; t.pc1 = pc1; t.pc2 = pc2;
    return t;
  endfunction

  function automatic logic [31:0] pack(input logic p1, input logic p2, input logic d1, input logic d2,
                                       input logic [2:0] l1, input logic [2:0] l2,
                                       input logic [7:0] pc1, input logic [7:0] pc2);
    return {4'h0, p1, p2, d1, d2, 1'b0, l1, 1'b0, l2, pc1, pc2};
  endfunction

  // put_cor is only meaningful while the matching put is expected high
  function automatic logic [31:0] obs(input logic s1, input logic s2);
    return pack(p1_put, p2_put, p1_deny, p2_deny, p1_live, p2_live,
                s1 ? p1_put_cor : 8'h00, s2 ? p2_put_cor : 8'h00);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (put1 put2 deny1 deny2 | live1 | live2 | pc1 | pc2)", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    p1_req = 1'b0; p2_req = 1'b0;
    p1_cor = '0; p2_cor = '0;
    p1_cap = 3'd1; p2_cap = 3'd1;
    bomb_un_grid = '0; wall_occ = '0;
    repeat (2) tick();
    check("reset_state", obs(1'b1, 1'b1), pack(0, 0, 0, 0, 0, 0, 0, 0));
    #2 reset_n = 1'b1;
    tick();
    // single grant and full fuse lifetime
    p1_req = 1'b1; p1_cor = 8'h22; p1_cap = 3'd1;
    tick();
    check("put_0x22", obs(1'b1, 1'b0), pack(1, 0, 0, 0, 1, 0, 8'h22, 0));
    p1_req = 1'b0;
    tick();
    check("put_one_cycle", obs(1'b0, 1'b0), pack(0, 0, 0, 0, 1, 0, 0, 0));
    repeat (59) tick();
    check("fuse_live_60", obs(1'b0, 1'b0), pack(0, 0, 0, 0, 1, 0, 0, 0));
    tick();
    check("fuse_expired_61", obs(1'b0, 1'b0), pack(0, 0, 0, 0, 0, 0, 0, 0));

    // cooldown and cap 2
    tbl.push_back(mk(1, 0, 8'h10, 0, 2, 1, 0, 0, 1, 0, 0, 0, 1, 0, 8'h10, 0));
    tbl.push_back(mk(0, 0, 8'h10, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h11, 0, 2, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    repeat (2) tbl.push_back(mk(0, 0, 8'h11, 0, 2, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h11, 0, 2, 1, 0, 0, 1, 0, 0, 0, 2, 0, 8'h11, 0));
    repeat (4) tbl.push_back(mk(0, 0, 8'h11, 0, 2, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h12, 0, 2, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0));
    // same-tile conflict, round robin
    tbl.push_back(mk(0, 0, 0, 0, 4, 4, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h35, 8'h35, 4, 4, 0, 0, 1, 0, 0, 1, 3, 0, 8'h35, 0));
    repeat (4) tbl.push_back(mk(0, 0, 8'h35, 8'h35, 4, 4, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h35, 8'h35, 4, 4, 0, 0, 0, 1, 1, 0, 3, 1, 0, 8'h35));
    repeat (4) tbl.push_back(mk(0, 0, 8'h35, 8'h35, 4, 4, 0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
    // shadow of a freshly granted tile
    tbl.push_back(mk(1, 0, 8'h40, 0, 4, 4, 0, 0, 1, 0, 0, 0, 4, 1, 8'h40, 0));
    tbl.push_back(mk(0, 1, 8'h40, 8'h40, 4, 4, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 8'h40, 8'h40, 4, 4, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0));
    // wall and grid bomb
    tbl.push_back(mk(0, 1, 0, 8'h05, 4, 4, 9'h105, 0, 0, 0, 0, 1, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h05, 4, 4, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h05, 4, 4, 0, 9'h105, 0, 0, 0, 1, 4, 1, 0, 0));
    // cap reduction keeps slots; cap 0 acts as 1; cap 7 acts as 4
    tbl.push_back(mk(0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h06, 1, 0, 0, 0, 0, 0, 0, 1, 4, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h06, 1, 7, 0, 0, 0, 0, 0, 0, 4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h06, 1, 7, 0, 0, 0, 1, 0, 0, 4, 2, 0, 8'h06));

    foreach (tbl[i]) begin
      p1_req = tbl[i].r1; p2_req = tbl[i].r2;
      p1_cor = tbl[i].c1; p2_cor = tbl[i].c2;
      p1_cap = tbl[i].k1; p2_cap = tbl[i].k2;
      wall_occ = '0; bomb_un_grid = '0;
      if (tbl[i].wall[8]) wall_occ[tbl[i].wall[7:0]] = 1'b1;
      if (tbl[i].bomb[8]) bomb_un_grid[tbl[i].bomb[7:0]] = 1'b1;
      tick();
      check($sformatf("vec%0d", i), obs(tbl[i].p1, tbl[i].p2),
            pack(tbl[i].p1, tbl[i].p2, tbl[i].d1, tbl[i].d2, tbl[i].l1, tbl[i].l2, tbl[i].pc1, tbl[i].pc2));
    end

    // asynchronous reset while p2_put is high and bombs are live
    p1_req = 1'b0; p2_req = 1'b0;
    #2 reset_n = 1'b0;
    #1 check("async_reset", obs(1'b1, 1'b1), pack(0, 0, 0, 0, 0, 0, 0, 0));
    p1_req = 1'b1; p2_req = 1'b1;
    p1_cor = 8'h50; p2_cor = 8'h51;
    p1_cap = 3'd1; p2_cap = 3'd1;
    #3 reset_n = 1'b1;
    tick();
    check("held_req_a", obs(1'b0, 1'b0), pack(0, 0, 0, 0, 0, 0, 0, 0));
    tick();
    check("held_req_b", obs(1'b0, 1'b0), pack(0, 0, 0, 0, 0, 0, 0, 0));
    p1_req = 1'b0; p2_req = 1'b0;
    tick();
    p1_req = 1'b1; p2_req = 1'b1;
    tick();
    check("two_tiles_same_cycle", obs(1'b1, 1'b1), pack(1, 1, 0, 0, 1, 1, 8'h50, 8'h51));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bomb_put_arbiter.md
# bomb_put_arbiter

Sits between the player input/movement logic and the bomb grid and decides which bomb-placement requests are accepted. It edge-detects each player's put request, checks the target tile, the player's capacity and a post-put cooldown, and resolves same-tile conflicts between players with round-robin priority. Accepted requests leave as registered one-cycle put strobes with a latched tile coordinate. Per-player fuse slots track how many bombs each player has live.

## Interface
- FUSE_TICKS, 61: cycles a granted bomb occupies a player slot; matches grid fuse of 60 plus 1.
- COOLDOWN, 4: cycles a player is blocked after a grant.
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- p1_req, p2_req  in  1 each  raw put request level; acts on rising edge only
- p1_cor, p2_cor  in  8 each  current tile index, row*16+col
- p1_cap, p2_cap  in  3 each  max live bombs; 0 is treated as 1, values above 4 as 4
- bomb_un_grid  in  256  unexploded-bomb occupancy from grid
- wall_occ  in  256  1 = tile blocked by a wall
- p1_put, p2_put  out  1 each  one-cycle grant strobe to the grid
- p1_put_cor, p2_put_cor  out  8 each  tile latched at grant; valid while the matching put is high
- p1_deny, p2_deny  out  1 each  one-cycle strobe when a rising edge is rejected
- p1_live, p2_live  out  3 each  occupied slots, 0..4

## Operation
- Edge detect: req_q is registered; rise = req & ~req_q. Level held high produces one evaluation only.
- Per-player FSM, states IDLE and COOL:
  - IDLE: a rise is evaluated.
  - On grant, go to COOL with the counter loaded to COOLDOWN.
  - COOL decrements each cycle and returns to IDLE when the counter is 0.
  - A rise seen in COOL produces deny.
- A player is eligible when all of these hold:
  - FSM is IDLE;
  - wall_occ[cor]=0;
  - bomb_un_grid[cor]=0;
  - tile is not shadowed;
  - live < effective cap.
- Shadow: each granted tile is held for 2 cycles after its put strobe and treated as occupied, to cover grid update lag. The shadow applies to both players.
- Same-tile conflict: both rise on the same tile and both are eligible.
  - The player named by prio (reset value P1) is granted; the other gets deny.
  - prio toggles to the loser.
  - prio does not change when there is no conflict.
- Different tiles: both players may be granted in the same cycle.
- Fuse slots: 4 per player, each with a 7-bit down counter.
  - A grant loads the lowest-index free slot (counter = 0) with FUSE_TICKS.
  - Nonzero counters decrement every cycle.
  - live = count of nonzero slots.
  - A slot that reaches 0 is free in the same cycle, so a grant in that cycle may reuse it.
- A cap reduction below live never clears slots; it only blocks new grants.

## Timing
- A rise sampled at edge t produces put/deny high during cycle t+1, for exactly one cycle.
- put_cor equals cor as sampled at edge t.
- live increments in the cycle put is high.
- After a grant, the earliest next grant for the same player is COOLDOWN+1 cycles after the put.
- Reset values of all outputs: put, deny, put_cor, live are 0. prio=P1, FSMs are IDLE, all slots 0, req_q=0.
- A request held high through reset deassertion does not generate a rise.
- Reset mid-operation clears everything immediately. Live bombs already in the grid are not tracked afterwards.

## Configuration
- BOMB_ARB_STATS_EN defined:
  - adds outputs p1_grant_cnt, p2_grant_cnt and conflict_cnt, 8 bits each, saturating at 255, reset to 0;
  - conflict_cnt increments once per same-tile conflict.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

## Structure
- bomb_pkg holds:
  - constants: GRID_W=16, GRID_N=256, MAX_BOMBS=4;
  - the arbiter FSM state enum;
  - player id typedef (P1=0, P2=1);
  - the tile-state enum shared with the grid.
- Sub-module bomb_slot_tracker, instantiated once per player:
  - holds the 4 fuse counters, the free-slot pick and the live count;
  - inputs: grant and effective cap; outputs: live and full.

## Test plan
- P1 at tile 0x22, free, cap 1, req rises → p1_put=1 next cycle, put_cor=0x22, p1_live=1. After 61 cycles p1_live=0.
- P1 cap 2: grant at 0x10, then a rise 1 cycle after the put (COOL) → deny. A rise at COOLDOWN+1 cycles on 0x11 → grant, live=2. A third rise after cooldown → deny (cap reached).
- Both rise on 0x35 → P1 granted, P2 denied, prio=P2. Repeat after cooldown → P2 granted, P1 denied.
- P1 granted 0x40; P2 rises on 0x40 one cycle later while bomb_un_grid[0x40]=0 → deny (shadow).
- wall_occ[0x05]=1 or bomb_un_grid[0x05]=1, P2 rises on 0x05 → p2_deny, live unchanged. Different-tile simultaneous rises → both puts in the same cycle.
- reset_n pulled low mid-fuse with live=3 → all outputs 0 immediately. Req held high across release → no put.
